// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one floating-point adder between NREQ requesters.
// Each grant resets the adder, strobes start, then waits for ready or a timeout.
module fp_add_arbiter #(
  parameter int expWidth      = 7,
  parameter int mantissaWidth = 24,
  parameter int NREQ          = 4,
  parameter int TIMEOUT       = 200,
  localparam int W            = expWidth + mantissaWidth + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  output logic [NREQ-1:0]   done,
  output logic              err,
  output logic [W-1:0]      result,
  output logic              busy,
  output logic [2:0]        grant_id,
  output logic [W-1:0]      add_a,
  output logic [W-1:0]      add_b,
  output logic              add_start,
  output logic              add_rst_n,
  input  logic              add_ready,
  input  logic [W-1:0]      add_s
);

  typedef enum logic [2:0] {IDLE, CLEAR, LAUNCH, BUSY, DONE} state_t;

  localparam logic [15:0] TO_CYC = 16'(TIMEOUT);

  state_t            state_q, state_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        gid_q, gid_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [W-1:0]      a_q, a_d, b_q, b_d;
  logic [W-1:0]      res_q, res_d;
  logic              tout_q, tout_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              err_q, err_d;
  logic              start_q, start_d;
  logic              arst_q, arst_d;
  logic              busy_q, busy_d;

  logic              found;
  logic [2:0]        win;
  logic [3:0]        idx;
  logic [W-1:0]      win_a, win_b;

  // Scan upward from ptr with wrap; the first requesting index wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    win_a = '0;
    win_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = 4'(ptr_q) + 4'(i);
      if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!found && req[j] && (idx == 4'(j))) begin
          found = 1'b1;
          win   = 3'(j);
        end
      end
    end
    for (int unsigned j = 0; j < NREQ; j++) begin
      if (win == 3'(j)) begin
        win_a = op_a[j*W +: W];
        win_b = op_b[j*W +: W];
      end
    end
  end

  // Strobe outputs are registered from the current state, so each appears
  // one cycle after the state that owns it (add_start lands in the first BUSY cycle).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    tout_d  = tout_q;
    done_d  = '0;
    err_d   = 1'b0;
    start_d = 1'b0;
    arst_d  = 1'b1;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gid_d   = win;
          a_d     = win_a;
          b_d     = win_b;
          tout_d  = 1'b0;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        arst_d  = 1'b0;
        state_d = LAUNCH;
      end
      LAUNCH: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q + 16'd1;
        if (add_ready) begin
          res_d   = add_s;
          state_d = DONE;
        end else if (cnt_d >= TO_CYC) begin
          res_d   = '1;
          tout_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        for (int unsigned i = 0; i < NREQ; i++) begin
          done_d[i] = (gid_q == 3'(i));
        end
        err_d   = tout_q;
        ptr_d   = (gid_q >= 3'(NREQ - 1)) ? 3'd0 : gid_q + 3'd1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gid_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      tout_q  <= 1'b0;
      done_q  <= '0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      arst_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      tout_q  <= tout_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      arst_q  <= arst_d;
      busy_q  <= busy_d;
    end
  end

  assign done      = done_q;
  assign err       = err_q;
  assign result    = res_q;
  assign busy      = busy_q;
  assign grant_id  = gid_q;
  assign add_a     = a_q;
  assign add_b     = b_q;
  assign add_start = start_q;
  assign add_rst_n = arst_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Self-checking bench for fp_add_arbiter: behavioural adder model plus
// a round-robin reference model driven by randomized requests.
module tb_fp_add_arbiter;
  localparam int E  = 7;
  localparam int M  = 24;
  localparam int N  = 4;
  localparam int TO = 20;
  localparam int W  = E + M + 1;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] op_a, op_b;
  logic [N-1:0]   done;
  logic           err, busy, add_start, add_rst_n;
  logic [W-1:0]   result, add_a, add_b, add_s;
  logic [2:0]     grant_id;
  logic           add_ready;

  int pass_cnt = 0;
  int check_cnt = 0;

  // adder model controls
  int   adder_lat = 1;
  logic adder_never = 1'b0;
  logic preset_ready = 1'b0;
  logic pend;
  int   lat_cnt;

  fp_add_arbiter #(.expWidth(E), .mantissaWidth(M), .NREQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .op_a(op_a), .op_b(op_b),
    .done(done), .err(err), .result(result), .busy(busy), .grant_id(grant_id),
    .add_a(add_a), .add_b(add_b), .add_start(add_start), .add_rst_n(add_rst_n),
    .add_ready(add_ready), .add_s(add_s)
  );

  always #5 clk = ~clk;

  // Same-sign normalised add with truncation (1 sign, 7 exp, 24 mantissa bits).
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] x, y;
    logic [6:0]  d;
    logic [24:0] mx, my;
    logic [25:0] s;
    if (a[30:24] >= b[30:24]) begin x = a; y = b; end
    else begin x = b; y = a; end
    d  = x[30:24] - y[30:24];
    mx = {1'b1, x[23:0]};
    my = {1'b1, y[23:0]} >> d;
    s  = {1'b0, mx} + {1'b0, my};
    if (s[25]) return {x[31], x[30:24] + 7'd1, s[24:1]};
    return {x[31], x[30:24], s[23:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [6:0] e;
    logic [23:0] m;
    e = 7'($urandom_range(20, 100));
    m = 24'($urandom);
    return {1'b0, e, m};
  endfunction

  // Adder with sticky ready, cleared asynchronously by add_rst_n.
  always @(posedge clk or negedge add_rst_n) begin
    if (!add_rst_n) begin
      add_ready <= 1'b0;
      pend      <= 1'b0;
      lat_cnt   <= 0;
    end else begin
      if (preset_ready) add_ready <= 1'b1;
      if (add_start && !adder_never) begin
        add_s <= fp_add(add_a, add_b);
        if (adder_lat == 0) add_ready <= 1'b1;
        else begin pend <= 1'b1; lat_cnt <= adder_lat - 1; end
      end else if (pend) begin
        if (lat_cnt == 0) begin add_ready <= 1'b1; pend <= 1'b0; end
        else lat_cnt <= lat_cnt - 1;
      end
    end
  end

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    op_a[i*W +: W] = a;
    op_b[i*W +: W] = b;
  endtask

  task automatic do_reset();
    reset = 1'b0; req = '0; preset_ready = 1'b0; adder_never = 1'b0; adder_lat = 1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_done(input int max_cyc, output int cyc, output logic ok);
    cyc = 0; ok = 1'b0;
    while (!ok && cyc < max_cyc) begin
      @(negedge clk); cyc++;
      if (done !== '0) ok = 1'b1;
    end
  endtask

  task automatic wait_start(input int max_cyc, output int cyc, output logic ok);
    cyc = 0; ok = 1'b0;
    while (!ok && cyc < max_cyc) begin
      @(negedge clk); cyc++;
      if (add_start === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    check_cnt++;
    if ({done, err, busy, result, grant_id, add_a, add_b, add_start, add_rst_n} !== '0)
      $display("FAIL reset_values: done=%b err=%b busy=%b res=%h gid=%0d a=%h b=%h st=%b arn=%b, want all 0",
               done, err, busy, result, grant_id, add_a, add_b, add_start, add_rst_n);
    else pass_cnt++;
    reset = 1'b1;
    #1;
    check_cnt++;
    if (add_rst_n !== 1'b0) $display("FAIL rst_n_before_edge: got %b want 0", add_rst_n); else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if ({add_rst_n, busy} !== 2'b10) $display("FAIL rst_n_rise: got arn=%b busy=%b want 1/0", add_rst_n, busy); else pass_cnt++;
  endtask

  task automatic test_single_add();
    int n;
    logic hit;
    do_reset();
    adder_lat = 0;
    set_op(0, 32'h3F000000, 32'h3F000000);
    req = 4'b0001;
    hit = 1'b0; n = 0;
    while (!hit && n < 40) begin
      @(negedge clk); n++;
      if (n == 1) begin
        check_cnt++;
        if ({busy, grant_id, add_a, add_b} !== {1'b1, 3'd0, 32'h3F000000, 32'h3F000000})
          $display("FAIL single_grant: got busy=%b gid=%0d a=%h b=%h want 1/0/3f000000/3f000000", busy, grant_id, add_a, add_b);
        else pass_cnt++;
      end
      if (n == 2) begin
        check_cnt++;
        if ({add_rst_n, add_start} !== 2'b00) $display("FAIL single_clear: got arn/st=%b%b want 00", add_rst_n, add_start); else pass_cnt++;
      end
      if (n == 3) begin
        check_cnt++;
        if ({add_rst_n, add_start} !== 2'b11) $display("FAIL single_launch: got arn/st=%b%b want 11", add_rst_n, add_start); else pass_cnt++;
      end
      if (done !== '0) hit = 1'b1;
    end
    req = '0;
    check_cnt++;
    if (!hit || n != 6) $display("FAIL single_latency: got hit=%b cycles=%0d want 1/6", hit, n); else pass_cnt++;
    check_cnt++;
    if ({done, err, result} !== {4'b0001, 1'b0, 32'h40000000})
      $display("FAIL single_result: got done=%b err=%b res=%h want 0001/0/40000000", done, err, result);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if (done !== '0) $display("FAIL single_pulse_width: got done=%b want 0000", done); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [31:0] ma[N], mb[N];
    int w, cyc;
    logic ok;
    do_reset();
    adder_lat = $urandom_range(0, 3);
    for (int i = 0; i < N; i++) begin
      ma[i] = rand_op(); mb[i] = rand_op(); set_op(i, ma[i], mb[i]);
    end
    req = 4'b1111;
    w = 0;
    for (int k = 0; k < 6; k++) begin
      wait_done(60, cyc, ok);
      check_cnt++;
      if (!ok || done !== 4'(1 << w))
        $display("FAIL rr_order[%0d]: got done=%b want %b", k, done, 4'(1 << w));
      else pass_cnt++;
      check_cnt++;
      if (result !== fp_add(ma[w], mb[w]))
        $display("FAIL rr_result[%0d]: got %h want %h", k, result, fp_add(ma[w], mb[w]));
      else pass_cnt++;
      w = (w + 1) % N;
    end
    req = '0;
  endtask

  task automatic test_stuck_ready();
    int cyc, ready_cyc, done_cyc;
    logic ok;
    do_reset();
    adder_lat = 6;
    preset_ready = 1'b1;
    @(negedge clk);
    preset_ready = 1'b0;
    check_cnt++;
    if (add_ready !== 1'b1) $display("FAIL stuck_preset: got ready=%b want 1", add_ready); else pass_cnt++;
    set_op(2, 32'h3F800000, 32'h3F400000);
    req = 4'b0100;
    wait_start(20, cyc, ok);
    check_cnt++;
    if (!ok || add_ready !== 1'b0) $display("FAIL stuck_cleared: got start=%b ready=%b want 1/0", ok, add_ready); else pass_cnt++;
    ready_cyc = 0; done_cyc = 0; cyc = 0;
    while (done_cyc == 0 && cyc < 60) begin
      @(negedge clk); cyc++;
      if (ready_cyc == 0 && add_ready === 1'b1) ready_cyc = cyc;
      if (done !== '0) done_cyc = cyc;
    end
    req = '0;
    check_cnt++;
    if (ready_cyc == 0 || done_cyc != ready_cyc + 2)
      $display("FAIL stuck_done_after_ready: got ready@%0d done@%0d want done=ready+2", ready_cyc, done_cyc);
    else pass_cnt++;
    check_cnt++;
    if ({done, err, result} !== {4'b0100, 1'b0, fp_add(32'h3F800000, 32'h3F400000)})
      $display("FAIL stuck_result: got done=%b err=%b res=%h", done, err, result);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int cyc;
    logic ok;
    do_reset();
    adder_never = 1'b1;
    set_op(3, rand_op(), rand_op());
    req = 4'b1000;
    wait_start(20, cyc, ok);
    wait_done(TO + 20, cyc, ok);
    req = '0;
    check_cnt++;
    if (!ok || cyc != TO + 1) $display("FAIL timeout_cycles: got ok=%b cycles=%0d want %0d", ok, cyc, TO + 1); else pass_cnt++;
    check_cnt++;
    if ({done, err, result} !== {4'b1000, 1'b1, 32'hFFFFFFFF})
      $display("FAIL timeout_result: got done=%b err=%b res=%h want 1000/1/ffffffff", done, err, result);
    else pass_cnt++;
    @(negedge clk);
    check_cnt++;
    if ({done, err} !== 5'b0) $display("FAIL timeout_err_pulse: got done=%b err=%b want 0", done, err); else pass_cnt++;
    adder_never = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    int cyc;
    logic ok, any_done;
    do_reset();
    req = 4'b0001;
    wait_done(40, cyc, ok);
    req = 4'b0011;
    @(negedge clk);
    adder_never = 1'b1;
    req = 4'b0011;
    wait_start(20, cyc, ok);
    check_cnt++;
    if (!ok || grant_id !== 3'd1) $display("FAIL midrst_pre_grant: got gid=%0d want 1", grant_id); else pass_cnt++;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check_cnt++;
    if ({done, err, busy, result, grant_id, add_a, add_b, add_start, add_rst_n} !== '0)
      $display("FAIL midrst_async: done=%b err=%b busy=%b res=%h gid=%0d a=%h b=%h st=%b arn=%b, want all 0",
               done, err, busy, result, grant_id, add_a, add_b, add_start, add_rst_n);
    else pass_cnt++;
    any_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== '0) any_done = 1'b1;
    end
    check_cnt++;
    if (any_done) $display("FAIL midrst_no_done: got a done pulse want none"); else pass_cnt++;
    adder_never = 1'b0;
    reset = 1'b1;
    wait_done(40, cyc, ok);
    req = '0;
    check_cnt++;
    if (!ok || done !== 4'b0001) $display("FAIL midrst_ptr0: got done=%b want 0001", done); else pass_cnt++;
  endtask

  task automatic test_drop_req();
    int cyc;
    logic ok;
    do_reset();
    req = 4'b0001;
    wait_done(40, cyc, ok);
    req = 4'b0011;
    @(negedge clk);
    check_cnt++;
    if ({busy, grant_id} !== {1'b1, 3'd1}) $display("FAIL drop_grant: got busy=%b gid=%0d want 1/1", busy, grant_id); else pass_cnt++;
    @(negedge clk);
    req = 4'b0001;
    wait_done(40, cyc, ok);
    check_cnt++;
    if (!ok || {done, err} !== {4'b0010, 1'b0}) $display("FAIL drop_done1: got done=%b err=%b want 0010/0", done, err); else pass_cnt++;
    wait_done(40, cyc, ok);
    req = '0;
    check_cnt++;
    if (!ok || done !== 4'b0001) $display("FAIL drop_next0: got done=%b want 0001", done); else pass_cnt++;
  endtask

  task automatic test_random();
    logic [31:0] ma[N], mb[N];
    logic [N-1:0] req_prev;
    logic busy_prev;
    int ptr_m, cur, exp_w;
    do_reset();
    ptr_m = 0; cur = 0; busy_prev = 1'b0; req_prev = '0;
    for (int i = 0; i < N; i++) begin ma[i] = '0; mb[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!busy_prev && busy) begin
        exp_w = -1;
        for (int s = 0; s < N; s++)
          if (exp_w < 0 && req_prev[(ptr_m + s) % N]) exp_w = (ptr_m + s) % N;
        check_cnt++;
        if (exp_w < 0 || {grant_id, add_a, add_b} !== {3'(exp_w), ma[exp_w], mb[exp_w]})
          $display("FAIL rand_grant@%0d: got gid=%0d a=%h b=%h want gid=%0d", c, grant_id, add_a, add_b, exp_w);
        else pass_cnt++;
        if (exp_w >= 0) cur = exp_w;
      end
      if (done !== '0) begin
        check_cnt++;
        if ({done, err, result} !== {4'(1 << cur), 1'b0, fp_add(ma[cur], mb[cur])})
          $display("FAIL rand_done@%0d: got done=%b err=%b res=%h want %b/0/%h", c, done, err, result, 4'(1 << cur), fp_add(ma[cur], mb[cur]));
        else pass_cnt++;
        ptr_m = (cur + 1) % N;
        req[cur] = 1'b0;
      end
      busy_prev = busy;
      adder_lat = $urandom_range(0, 4);
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          ma[i] = rand_op(); mb[i] = rand_op(); set_op(i, ma[i], mb[i]); req[i] = 1'b1;
        end
      end
      req_prev = req;
    end
    req = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b0; req = '0; op_a = '0; op_b = '0;
    test_reset();
    test_single_add();
    test_round_robin();
    test_stuck_ready();
    test_timeout();
    test_reset_mid_busy();
    test_drop_req();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
